rca4_sequencer: RTL and testbench

Multi-cycle, multi-precision adder controller that adds two `4*NIBBLES`-bit operands plus carry-in by reusing a single 4-bit ripple-carry slice, one nibble per cycle, least-significant nibble first. The slice's carry-out is registered and fed back as the next nibble's carry-in. The block sits between a valid/ready producer and a valid/ready consumer. It trades latency for area: one 4-bit slice replaces a full-width carry chain.

---
 rtl/rca4_sequencer.sv | 102 ++++++++++
 tb/tb_rca4_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rca4_sequencer.sv
// Multi-precision adder controller: one 4-bit ripple-carry slice is reused once per nibble,
// least-significant nibble first, between a valid/ready producer and a valid/ready consumer.
module rca4_sequencer #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 carry_out,
   output logic                 busy
);
   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
   logic            c_q, c_d;
   logic [IdxW-1:0] idx_q, idx_d;

   logic [IdxW+1:0] bit_off;
   logic [3:0]      slice_a, slice_b, slice_s;
   logic [2:0]      lo_sum, hi_sum;
   logic            slice_co, idx_last;

   // Single 4-bit slice built from two 2-bit stages; carry chain passes lo -> hi.
   assign bit_off  = {idx_q, 2'b00};
   assign slice_a  = a_q[bit_off +: 4];
   assign slice_b  = b_q[bit_off +: 4];
   assign lo_sum   = {1'b0, slice_a[1:0]} + {1'b0, slice_b[1:0]} + {2'b00, c_q};
   assign hi_sum   = {1'b0, slice_a[3:2]} + {1'b0, slice_b[3:2]} + {2'b00, lo_sum[2]};
   assign slice_s  = {hi_sum[1:0], lo_sum[1:0]};
   assign slice_co = hi_sum[2];
   assign idx_last = (idx_q == IdxW'(NIBBLES - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               c_d     = cin;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            s_d[bit_off +: 4] = slice_s;
            c_d               = slice_co;
            if (idx_last) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign sum       = s_q;
   assign carry_out = c_q;
endmodule

// File: tb/tb_rca4_sequencer.sv
// Directed and random checks of rca4_sequencer for NIBBLES=4 and NIBBLES=1.
module tb_rca4_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv4, ir4, ov4, or4, co4, busy4, cin4;
   logic [15:0] a4, b4, s4;
   logic        iv1, ir1, ov1, or1, co1, busy1, cin1;
   logic [3:0]  a1, b1, s1;

   int n_checks = 0;
   int n_pass   = 0;

   rca4_sequencer #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ov4), .out_ready(or4), .sum(s4), .carry_out(co4), .busy(busy4)
   );

   rca4_sequencer #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1), .busy(busy1)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   // One NIBBLES=4 transaction; holds out_ready low for gap cycles in DONE.
   task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic eco, input int gap);
      int lat;
      int w;
      @(negedge clk);
      w = 0;
      while (!ir4 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!ir4) check("in_ready_wait", ir4, 1);
      iv4 = 1'b1; a4 = a; b4 = b; cin4 = c;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      lat = 1;
      while (!ov4 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 5);
      check("sum", s4, es);
      check("carry_out", co4, eco);
      check("busy_done", busy4, 1);
      check("in_ready_done", ir4, 0);
      for (int i = 0; i < gap; i++) begin
         iv4 = (i == 0); a4 = 16'h1111; b4 = 16'h2222;
         @(negedge clk);
         iv4 = 1'b0;
         check("bp_sum", s4, es);
         check("bp_carry", co4, eco);
         check("bp_out_valid", ov4, 1);
         check("bp_in_ready", ir4, 0);
      end
      or4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or4 = 1'b0;
      check("in_ready_after_release", ir4, 1);
      check("out_valid_after_release", ov4, 0);
   endtask

   task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] es, input logic eco);
      int lat;
      @(negedge clk);
      check("n1_in_ready", ir1, 1);
      iv1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      @(posedge clk);
      @(negedge clk);
      iv1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
      lat = 1;
      while (!ov1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("n1_latency", lat, 2);
      check("n1_sum", s1, es);
      check("n1_carry", co1, eco);
      or1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or1 = 1'b0;
      check("n1_in_ready_after", ir1, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra, rb, rs;
      logic        rc, rco;

      rst = 1'b1;
      iv4 = 0; or4 = 0; cin4 = 0; a4 = 0; b4 = 0;
      iv1 = 0; or1 = 0; cin1 = 0; a1 = 0; b1 = 0;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
      vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
      vecs[9] = '{16'h0008, 16'h0007, 1'b1, 16'h0010, 1'b0};

      @(posedge clk);
      #1;
      check("rst_in_ready", ir4, 1);
      check("rst_out_valid", ov4, 0);
      check("rst_busy", busy4, 0);
      check("rst_sum", s4, 0);
      check("rst_carry", co4, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, 0);
      end

      // Backpressure with an ignored in_valid inside the DONE window.
      op4(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 3);

      // Reset after two nibble edges of a RUN.
      @(negedge clk);
      iv4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; cin4 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid_run_busy_before", busy4, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_sum", s4, 0);
      check("mid_rst_out_valid", ov4, 0);
      check("mid_rst_busy", busy4, 0);
      check("mid_rst_in_ready", ir4, 1);
      check("mid_rst_carry", co4, 0);
      @(negedge clk);
      rst = 1'b0;
      op4(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);

      op1(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
      op1(4'h3, 4'h4, 1'b1, 4'h8, 1'b0);
      op1(4'h9, 4'h9, 1'b1, 4'h3, 1'b1);

      for (int k = 0; k < 1000; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         {rco, rs} = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
         op4(ra, rb, rc, rs, rco, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
